// File: rtl/npr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : npr_arbiter
// Desc     : Round-robin Unibus NPR mastership arbiter for internal DMA
//            requesters; optional grant-wait timeout via NPRARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module npr_arbiter #(
  parameter int NREQ     = 4,
  parameter int DEGLITCH = 4,
  parameter int TOWIDTH  = 10
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic            init_in_h,
  input  logic            halted,
  input  logic            npg_in_l,
  input  logic            bbsy_in_h,
  input  logic            ssyn_in_h,
  input  logic [NREQ-1:0] req,
  output logic            npr_out_h,
  output logic            sack_out_h,
  output logic            bbsy_out_h,
  output logic            npg_out_l,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] fail,
  output logic            busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(DEGLITCH + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_DEGL    = 3'd2;
  localparam logic [2:0] S_SACKW   = 3'd3;
  localparam logic [2:0] S_WAITBUS = 3'd4;
  localparam logic [2:0] S_OWN     = 3'd5;
  localparam logic [2:0] S_REL     = 3'd6;

  logic [2:0]      r_state, w_state_nxt;
  logic [IW-1:0]   r_last, r_win, w_pick, w_idx;
  logic [CW-1:0]   r_cnt, w_cnt_inc;
  logic            r_npr, r_sack, r_bbsy, r_busy;
  logic [NREQ-1:0] r_gnt, r_fail;
  logic            w_npr_nxt, w_sack_nxt, w_bbsy_nxt, w_busy_nxt;
  logic [NREQ-1:0] w_gnt_nxt, w_fail_nxt;
  logic [NREQ-1:0] w_req_ok, w_win_oh;
  logic            w_any, w_own_req, w_to_hit, w_timeout;

`ifdef NPRARB_TIMEOUT_EN
  logic [TOWIDTH-1:0] r_to;
  logic [NREQ-1:0]    r_blk;
  assign w_to_hit = &r_to;
  // A requester that timed out stays masked until it drops its request.
  assign w_req_ok = req & ~r_blk;
`else
  logic [TOWIDTH-1:0] w_unused_to;
  assign w_unused_to = '0;
  assign w_to_hit    = 1'b0;
  assign w_req_ok    = req;
`endif

  assign w_any     = |w_req_ok;
  assign w_own_req = req[r_win];
  assign w_win_oh  = NREQ'(1) << r_win;
  assign w_cnt_inc = r_cnt + CW'(1);

  // Lowest offset from last+1 wins, so scan offsets from the top down.
  always_comb begin
    w_pick = r_last;
    w_idx  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = IW'((int'(r_last) + k) % NREQ);
      if (w_req_ok[w_idx]) w_pick = w_idx;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          if (halted)        w_state_nxt = S_WAITBUS;
          else if (npg_in_l) w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (!w_own_req) w_state_nxt = S_IDLE;
        else if (w_to_hit) begin
          w_state_nxt = S_IDLE;
          w_timeout   = 1'b1;
        end else if (!npg_in_l) w_state_nxt = S_DEGL;
      end
      S_DEGL: begin
        if (!w_own_req) w_state_nxt = S_IDLE;
        else if (w_to_hit) begin
          w_state_nxt = S_IDLE;
          w_timeout   = 1'b1;
        end else if (npg_in_l) w_state_nxt = S_REQ;
        else if (w_cnt_inc >= CW'(DEGLITCH)) w_state_nxt = S_SACKW;
      end
      S_SACKW:   if (npg_in_l) w_state_nxt = S_WAITBUS;
      S_WAITBUS: if (!bbsy_in_h && !ssyn_in_h) w_state_nxt = S_OWN;
      S_OWN:     if (!w_own_req) w_state_nxt = S_REL;
      S_REL:     w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
    if (init_in_h) begin
      w_state_nxt = S_IDLE;
      w_timeout   = 1'b0;
    end
  end

  // SACK survives into WAITBUS only on the NPR path; the halted path never raises it.
  always_comb begin
    w_npr_nxt  = (w_state_nxt == S_REQ) || (w_state_nxt == S_DEGL);
    w_sack_nxt = (w_state_nxt == S_SACKW) || ((w_state_nxt == S_WAITBUS) && r_sack);
    w_bbsy_nxt = (w_state_nxt == S_OWN);
    w_gnt_nxt  = w_bbsy_nxt ? w_win_oh : '0;
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_fail_nxt = w_timeout ? w_win_oh : '0;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_last  <= IW'(NREQ - 1);
      r_win   <= '0;
      r_cnt   <= '0;
      r_npr   <= 1'b0;
      r_sack  <= 1'b0;
      r_bbsy  <= 1'b0;
      r_busy  <= 1'b0;
      r_gnt   <= '0;
      r_fail  <= '0;
`ifdef NPRARB_TIMEOUT_EN
      r_to    <= '0;
      r_blk   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_npr   <= w_npr_nxt;
      r_sack  <= w_sack_nxt;
      r_bbsy  <= w_bbsy_nxt;
      r_busy  <= w_busy_nxt;
      r_gnt   <= w_gnt_nxt;
      r_fail  <= w_fail_nxt;
      if ((r_state == S_IDLE) && w_any) r_win <= w_pick;
      if (w_timeout || ((r_state == S_WAITBUS) && (w_state_nxt == S_OWN))) r_last <= r_win;
      if (w_state_nxt == S_DEGL) r_cnt <= (r_state == S_DEGL) ? w_cnt_inc : CW'(1);
      else                       r_cnt <= '0;
`ifdef NPRARB_TIMEOUT_EN
      r_to  <= ((r_state == S_REQ) || (r_state == S_DEGL)) ? r_to + TOWIDTH'(1) : '0;
      r_blk <= (r_blk & req) | w_fail_nxt;
`endif
    end
  end

  assign npr_out_h  = r_npr;
  assign sack_out_h = r_sack;
  assign bbsy_out_h = r_bbsy;
  assign gnt        = r_gnt;
  assign fail       = r_fail;
  assign busy       = r_busy;
  assign npg_out_l  = npg_in_l | r_npr | r_sack | (r_state == S_DEGL) | (r_state == S_SACKW);

endmodule
`default_nettype wire
